multicycle_datapath: RTL and testbench

//  Multicycle successor to the single-cycle MIPS datapath: datapath plus main-control FSM in one block.

---
 rtl/multicycle_pkg.sv | 69 ++++++
 rtl/mc_regfile.sv | 31 +++
 rtl/multicycle_datapath.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared types, encodings and helpers for the multicycle MIPS datapath.
package multicycle_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_BAD
  } alu_op_e;

  typedef enum logic [1:0] {
    TC_NONE     = 2'b00,
    TC_ILLEGAL  = 2'b01,
    TC_MISALIGN = 2'b10,
    TC_TIMEOUT  = 2'b11
  } trap_cause_e;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic alu_op_e funct_to_alu_op(input logic [5:0] funct);
    alu_op_e op;
    case (funct)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_BAD;
    endcase
    return op;
  endfunction

  // add/sub wrap modulo 2^32; slt is a signed compare
  function automatic logic [XLEN-1:0] alu(input alu_op_e op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLT: r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two async read ports, one sync write port, $0 reads 0.
// Ports: clk_i, rst_i (sync clear), we_i/waddr_i/wdata_i write port,
//        raddr_a_i/rdata_a_o and raddr_b_i/rdata_b_o read ports.
module mc_regfile
  import multicycle_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [XLEN-1:0]   rdata_a_o,
  output logic [XLEN-1:0]   rdata_b_o
);

  logic [XLEN-1:0] rf_q [32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : rf_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : rf_q[raddr_b_i];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS datapath + main control FSM sharing one req/ready memory port,
// with a per-access memory watchdog and a sticky trap.
// Ports: clock/reset (sync, active-high); mem_req/mem_we/mem_addr/mem_wdata out,
//        mem_rdata/mem_ready in; pc, instr_retired, trap, trap_cause status out.
module multicycle_datapath
  import multicycle_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        instr_retired,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam int unsigned WD_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned WD_CMP_W = WD_W + 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] alu_q, alu_d, mdr_q, mdr_d;
  logic            trap_q, trap_d;
  trap_cause_e     cause_q, cause_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic            req_c, we_c, retire_c, rf_we_c, timeout_hit_c;
  logic [XLEN-1:0] addr_c, rf_wdata_c, rs_val_c, rt_val_c, mem_ea_c;
  logic [REG_AW-1:0] rf_waddr_c;
  alu_op_e         alu_op_c;

  // Instruction fields
  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [15:0]       imm;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign imm    = ir_q[15:0];
  assign funct  = ir_q[5:0];

  mc_regfile u_regfile (
    .clk_i     (clock),
    .rst_i     (reset),
    .we_i      (rf_we_c),
    .waddr_i   (rf_waddr_c),
    .wdata_i   (rf_wdata_c),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rs_val_c),
    .rdata_b_o (rt_val_c)
  );

  assign mem_ea_c = a_q + sext16(imm);
  assign alu_op_c = funct_to_alu_op(funct);
  // Trip when this wait cycle would bring the count up to MEM_TIMEOUT
  assign timeout_hit_c = (MEM_TIMEOUT != 0) &&
      ((WD_CMP_W'(wd_q) + WD_CMP_W'(1)) == WD_CMP_W'(MEM_TIMEOUT));

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= TC_NONE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state and control
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    wd_d       = '0;
    req_c      = 1'b0;
    we_c       = 1'b0;
    addr_c     = pc_q;
    retire_c   = 1'b0;
    rf_we_c    = 1'b0;
    rf_waddr_c = '0;
    rf_wdata_c = '0;

    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rs_val_c;
        b_d   = rt_val_c;
        alu_d = pc_q + (sext16(imm) << 2);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = TC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alu_d = mem_ea_c;
        if (mem_ea_c[1:0] != 2'b00) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_MISALIGN;
        end else begin
          state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
      end
      S_MEMRD: begin
        req_c  = 1'b1;
        addr_c = alu_q;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we_c    = 1'b1;
        rf_waddr_c = rt;
        rf_wdata_c = mdr_q;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        req_c  = 1'b1;
        we_c   = 1'b1;
        addr_c = alu_q;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        if (alu_op_c == ALU_BAD) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_ILLEGAL;
        end else begin
          alu_d   = alu(alu_op_c, a_q, b_q);
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        rf_we_c    = 1'b1;
        rf_waddr_c = rd;
        rf_wdata_c = alu_q;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        if (a_q == b_q) pc_d = alu_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_d   = mem_ea_c;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we_c    = 1'b1;
        rf_waddr_c = rt;
        rf_wdata_c = alu_q;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_d     = {pc_q[31:28], ir_q[25:0], 2'b00};
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Watchdog overrides the handshake state when a wait runs too long
    if (req_c && !mem_ready) begin
      wd_d = wd_q + WD_W'(1);
      if (timeout_hit_c) begin
        state_d = S_TRAP;
        trap_d  = 1'b1;
        cause_d = TC_TIMEOUT;
      end
    end
  end

  // Handshake outputs are gated so a reset abandons any in-flight access at once
  assign mem_req       = req_c & ~reset;
  assign mem_we        = we_c & ~reset;
  assign instr_retired = retire_c & ~reset;
  assign mem_addr      = addr_c;
  assign mem_wdata     = b_q;
  assign pc            = pc_q;
  assign trap          = trap_q;
  assign trap_cause    = cause_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed testbench for multicycle_datapath with a wait-state memory responder.
module tb_multicycle_datapath;

  logic        clock;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, instr_retired, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic [1:0]  trap_cause;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  int          mem_wait = 0;
  logic        hold_low = 1'b0;
  logic        stall_writes = 1'b0;
  int          waited = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  multicycle_datapath #(.RESET_PC(32'h0), .MEM_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .instr_retired(instr_retired),
    .trap(trap), .trap_cause(trap_cause)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory responder: decides ready shortly after each falling edge
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      #1;
      if (mem_req && !hold_low && !(stall_writes && mem_we) && waited >= mem_wait) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) begin
          wr_cnt++;
          wr_addr = mem_addr;
          wr_data = mem_wdata;
        end
        waited = 0;
      end else begin
        mem_ready = 1'b0;
        if (mem_req) waited++;
        else waited = 0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Count cycles (starting at the first cycle after the current falling edge) until n retires
  task automatic run_retires(input int n, input int budget, output int cyc, output int r);
    r = 0;
    cyc = 0;
    while (r < n && cyc < budget) begin
      #2;
      cyc++;
      if (instr_retired) r++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    clear_mem();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #2;
    checks++;
    if (pc !== 32'h0 || trap !== 1'b0 || trap_cause !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: pc=%h trap=%b cause=%b expected pc=0 trap=0 cause=00", pc, trap, trap_cause);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || instr_retired !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b ret=%b expected 0 0 0", mem_req, mem_we, instr_retired);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_fetch: req=%b addr=%h we=%b expected 1 00000000 0", mem_req, mem_addr, mem_we);
    end
  endtask

  task automatic test_program();
    int cyc, r, w0;
    clear_mem();
    mem[0] = 32'h2001_0005;  // addi $1,$0,5
    mem[1] = 32'h2002_0007;  // addi $2,$0,7
    mem[2] = 32'h0022_1820;  // add  $3,$1,$2
    mem[3] = 32'hAC03_0000;  // sw   $3,0($0)
    mem_wait = 0;
    apply_reset();
    w0 = wr_cnt;
    run_retires(4, 40, cyc, r);
    checks++;
    if (cyc !== 16 || r !== 4) begin
      errors++;
      $display("FAIL prog_latency: cycles=%0d retires=%0d expected 16 4", cyc, r);
    end
    checks++;
    if (wr_cnt - w0 !== 1 || wr_addr !== 32'h0 || wr_data !== 32'd12) begin
      errors++;
      $display("FAIL prog_store: writes=%0d addr=%h data=%h expected 1 00000000 0000000c", wr_cnt - w0, wr_addr, wr_data);
    end
    checks++;
    if (pc !== 32'h10) begin
      errors++;
      $display("FAIL prog_pc: pc=%h expected 00000010", pc);
    end
  endtask

  task automatic test_lw_wait();
    // Expected per-cycle req/addr for lw with 3 wait states on fetch and data
    logic        exp_req [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
    logic [31:0] exp_adr [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h20, 32'h20, 32'h20, 32'h20, 32'h0};
    int cyc, r;
    clear_mem();
    mem[0] = 32'h8C05_0020;  // lw $5,0x20($0)
    mem[1] = 32'hAC05_0024;  // sw $5,0x24($0)
    mem[8] = 32'hDEAD_BEEF;
    mem_wait = 3;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      #2;
      checks++;
      if (mem_req !== exp_req[c] || (exp_req[c] && (mem_addr !== exp_adr[c] || mem_we !== 1'b0))) begin
        errors++;
        $display("FAIL lw_trace cycle %0d: req=%b addr=%h we=%b expected req=%b addr=%h we=0",
                 c + 1, mem_req, mem_addr, mem_we, exp_req[c], exp_adr[c]);
      end
      checks++;
      if (instr_retired !== (c == 10)) begin
        errors++;
        $display("FAIL lw_retire cycle %0d: retired=%b expected %b", c + 1, instr_retired, c == 10);
      end
      @(negedge clock);
    end
    run_retires(1, 30, cyc, r);
    checks++;
    if (cyc !== 10 || wr_addr !== 32'h24 || wr_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL lw_rt_value: cycles=%0d addr=%h data=%h expected 10 00000024 deadbeef", cyc, wr_addr, wr_data);
    end
    mem_wait = 0;
  endtask

  task automatic test_branch_jump();
    int cyc, r;
    clear_mem();
    mem[0] = 32'h0800_0004;  // j 0x10
    mem[4] = 32'h1000_FFFF;  // beq $0,$0,-1
    apply_reset();
    run_retires(1, 10, cyc, r);
    checks++;
    if (cyc !== 3 || pc !== 32'h10) begin
      errors++;
      $display("FAIL jump_to_10: cycles=%0d pc=%h expected 3 00000010", cyc, pc);
    end
    for (int k = 0; k < 3; k++) begin
      run_retires(1, 10, cyc, r);
      checks++;
      if (cyc !== 3 || pc !== 32'h10) begin
        errors++;
        $display("FAIL beq_loop %0d: cycles=%0d pc=%h expected 3 00000010", k, cyc, pc);
      end
    end
    mem[4] = 32'h0800_0040;  // j 0x40 -> 0x100
    apply_reset();
    run_retires(2, 20, cyc, r);
    checks++;
    if (cyc !== 6 || pc !== 32'h100) begin
      errors++;
      $display("FAIL jump_far: cycles=%0d pc=%h expected 6 00000100", cyc, pc);
    end
  endtask

  task automatic test_traps();
    clear_mem();
    mem[0] = 32'hFC00_0000;  // opcode 0x3F
    apply_reset();
    @(negedge clock);
    #2;
    checks++;
    if (trap !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pre: trap=%b expected 0", trap);
    end
    @(negedge clock);
    #2;
    checks++;
    if (trap !== 1'b1 || trap_cause !== 2'b01 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL illegal_trap: trap=%b cause=%b req=%b expected 1 01 0", trap, trap_cause, mem_req);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #2;
      checks++;
      if (mem_req !== 1'b0 || instr_retired !== 1'b0 || pc !== 32'h4) begin
        errors++;
        $display("FAIL illegal_frozen %0d: req=%b ret=%b pc=%h expected 0 0 00000004", k, mem_req, instr_retired, pc);
      end
    end

    clear_mem();
    mem[0] = 32'h2002_0002;  // addi $2,$0,2
    mem[1] = 32'h8C41_0000;  // lw $1,0($2)
    apply_reset();
    repeat (6) @(negedge clock);
    #2;
    checks++;
    if (trap !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pre: trap=%b expected 0", trap);
    end
    @(negedge clock);
    #2;
    checks++;
    if (trap !== 1'b1 || trap_cause !== 2'b10 || pc !== 32'h8) begin
      errors++;
      $display("FAIL misalign_trap: trap=%b cause=%b pc=%h expected 1 10 00000008", trap, trap_cause, pc);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #2;
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL misalign_noreq %0d: req=%b expected 0", k, mem_req);
      end
    end
  endtask

  task automatic test_timeout();
    int cyc, r;
    clear_mem();
    mem[0] = 32'h2001_0005;  // addi $1,$0,5
    hold_low = 1'b1;
    apply_reset();
    repeat (3) @(negedge clock);
    #2;
    checks++;
    if (trap !== 1'b0 || mem_req !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pre: trap=%b req=%b expected 0 1", trap, mem_req);
    end
    @(negedge clock);
    #2;
    checks++;
    if (trap !== 1'b1 || trap_cause !== 2'b11 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_trap: trap=%b cause=%b req=%b expected 1 11 0", trap, trap_cause, mem_req);
    end
    hold_low = 1'b0;
    mem_wait = 3;
    apply_reset();
    run_retires(1, 20, cyc, r);
    checks++;
    if (cyc !== 7 || r !== 1 || trap !== 1'b0) begin
      errors++;
      $display("FAIL timeout_edge_ok: cycles=%0d retires=%0d trap=%b expected 7 1 0", cyc, r, trap);
    end
    mem_wait = 0;
  endtask

  task automatic test_reset_mid_access();
    int w0;
    clear_mem();
    mem[0] = 32'hAC03_0000;  // sw $3,0($0)
    stall_writes = 1'b1;
    apply_reset();
    w0 = wr_cnt;
    repeat (4) @(negedge clock);
    #2;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL midwr_wait: req=%b we=%b addr=%h expected 1 1 00000000", mem_req, mem_we, mem_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL midwr_drop: req=%b we=%b expected 0 0", mem_req, mem_we);
    end
    @(negedge clock);
    #2;
    checks++;
    if (pc !== 32'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL midwr_pc: pc=%h req=%b expected 00000000 0", pc, mem_req);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h0 || wr_cnt !== w0) begin
      errors++;
      $display("FAIL midwr_refetch: req=%b we=%b addr=%h writes=%0d expected 1 0 00000000 0",
               mem_req, mem_we, mem_addr, wr_cnt - w0);
    end
    stall_writes = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_program();
    test_lw_wait();
    test_branch_jump();
    test_traps();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
